riscv_dmem_resp: RTL and testbench

//  Responder (slave) end of the core data-memory bus (dmem_*). Accepts one request at a time from
//  the core's MEM stage and serves it from a local word-organised SRAM with programmable wait states.

---
 rtl/riscv_dmem_resp.sv | 194 +++++++++++++++++++
 tb/tb_riscv_dmem_resp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp: dmem bus responder serving one request at a time from a local SRAM with wait states.
// Optional DMEM_PARITY_EN: per-byte even parity in the SRAM plus a par_inject port.
package riscv_dmem_resp_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;
endpackage

module riscv_dmem_resp
    import riscv_dmem_resp_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  biu_size_t       dmem_size,
`ifdef DMEM_PARITY_EN
    input  logic            par_inject,
`endif
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault
);

    localparam int unsigned     AW   = $clog2(DEPTH);
    localparam int unsigned     NB   = XLEN / 8;
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP,
        ST_ERR,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      wcnt;
    logic [AW-1:0]   idx_r;
    logic [XLEN-1:0] d_r;
    logic            we_r;
    logic [NB-1:0]   be_r;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] offset;
    logic [NB-1:0]   be;
    logic            misal, oor, bad_size;
    logic            load_req, q_load, ack_nxt, err_nxt, mis_nxt;
    logic            par_bad;

    logic [XLEN-1:0] mem [DEPTH];

    // Below-base addresses wrap to a huge offset, so one unsigned compare covers both bounds.
    always_comb begin
        offset   = dmem_adr - BASE_ADDR;
        oor      = offset >= SPAN;
        misal    = 1'b0;
        bad_size = 1'b0;
        be       = '0;
        case (dmem_size)
            BYTE:  be = NB'(1) << dmem_adr[1:0];
            HWORD: begin
                be    = NB'(3) << dmem_adr[1:0];
                misal = dmem_adr[0];
            end
            WORD: begin
                be    = '1;
                misal = |dmem_adr[1:0];
            end
            default: bad_size = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        q_load    = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        mis_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dmem_req) begin
                    if (misal || oor || bad_size) begin
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                        mis_nxt   = misal;
                    end else begin
                        load_req  = 1'b1;
                        state_nxt = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
            end
            ST_WAIT:   if (wcnt == 4'd1) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP: begin
                state_nxt = ST_DONE;
                if (!we_r && par_bad) begin
                    err_nxt = 1'b1;
                end else begin
                    ack_nxt = 1'b1;
                    q_load  = !we_r;
                end
            end
            ST_ERR:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            wcnt            <= '0;
            idx_r           <= '0;
            d_r             <= '0;
            we_r            <= 1'b0;
            be_r            <= '0;
            dmem_q          <= '0;
            dmem_ack        <= 1'b0;
            dmem_err        <= 1'b0;
            dmem_misaligned <= 1'b0;
        end else begin
            state           <= state_nxt;
            dmem_ack        <= ack_nxt;
            dmem_err        <= err_nxt;
            dmem_misaligned <= mis_nxt;
            if (load_req) begin
                idx_r <= offset[AW+1:2];
                d_r   <= dmem_d;
                we_r  <= dmem_we;
                be_r  <= be;
                wcnt  <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (q_load) dmem_q <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_ACCESS) begin
            if (we_r) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (be_r[i]) mem[idx_r][8*i +: 8] <= d_r[8*i +: 8];
                end
            end else begin
                rdata <= mem[idx_r];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_rd;

    always_ff @(posedge clk) begin
        if (state == ST_ACCESS) begin
            if (we_r) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (be_r[i]) par_mem[idx_r][i] <= (^d_r[8*i +: 8]) ^ par_inject;
                end
            end else begin
                par_rd <= par_mem[idx_r];
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_r[i] && ((^rdata[8*i +: 8]) != par_rd[i])) par_bad = 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    assign dmem_page_fault = 1'b0;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Randomized bench for riscv_dmem_resp: two instances (0 and 3 wait states) against a byte-level reference model.
module tb_riscv_dmem_resp;
    import riscv_dmem_resp_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned WIN   = 8;
`ifdef DMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        req  [2];
    logic [31:0] adr  [2];
    logic [31:0] d    [2];
    logic        we   [2];
    biu_size_t   size [2];
    logic        inj  [2];
    logic [31:0] q    [2];
    logic        ack  [2];
    logic        err  [2];
    logic        mis  [2];
    logic        pf   [2];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] last_q [2];
    logic [7:0]  ref_mem [longint];
    bit          ref_bad [longint];

    riscv_dmem_resp #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(d[0]),
        .dmem_we(we[0]), .dmem_size(size[0]),
`ifdef DMEM_PARITY_EN
        .par_inject(inj[0]),
`endif
        .dmem_q(q[0]), .dmem_ack(ack[0]), .dmem_err(err[0]),
        .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0])
    );

    riscv_dmem_resp #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(d[1]),
        .dmem_we(we[1]), .dmem_size(size[1]),
`ifdef DMEM_PARITY_EN
        .par_inject(inj[1]),
`endif
        .dmem_q(q[1]), .dmem_ack(ack[1]), .dmem_err(err[1]),
        .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint key(input int p, input logic [31:0] a);
        return (longint'(p) << 32) | longint'(a);
    endfunction

    function automatic logic [31:0] model_word(input int p, input logic [31:0] a);
        logic [31:0] b;
        b = a - (a % 4);
        return {ref_mem[key(p, b + 3)], ref_mem[key(p, b + 2)],
                ref_mem[key(p, b + 1)], ref_mem[key(p, b)]};
    endfunction

    task automatic txn(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic w, input logic [2:0] sz, input logic pinj);
        int unsigned nb, lat, exp_lat;
        logic        mis_e, err_e, par_e, ack_e, got;
        logic [31:0] q_e;
        logic [31:0] ga;
        longint      la;
        la    = longint'(a);
        nb    = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        mis_e = (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0);
        err_e = mis_e || sz > 3'd2 || la < longint'(BASE) || la >= longint'(BASE) + DEPTH * 4;
        par_e = 1'b0;
        q_e   = last_q[p];
        if (!err_e && !w) begin
            for (int unsigned k = 0; k < nb; k++) begin
                ga = a + k;
                if (ref_bad.exists(key(p, ga)) && ref_bad[key(p, ga)]) par_e = 1'b1;
            end
            if (!par_e) q_e = model_word(p, a);
        end
        ack_e   = !err_e && !par_e;
        exp_lat = err_e ? 1 : 3 + ((p == 0) ? 0 : 3);

        @(posedge clk); #1;
        req[p]  = 1'b1;
        adr[p]  = a;
        d[p]    = wd;
        we[p]   = w;
        size[p] = biu_size_t'(sz);
        inj[p]  = pinj;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack[p] || err[p]) got = 1'b1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("ack", 32'(ack[p]), 32'(ack_e));
        check("err", 32'(err[p]), 32'(!ack_e));
        check("misaligned", 32'(mis[p]), 32'(mis_e));
        check("page_fault", 32'(pf[p]), 32'd0);
        check("q", q[p], q_e);
        req[p] = 1'b0;
        inj[p] = 1'b0;

        if (!err_e && w) begin
            for (int unsigned k = 0; k < nb; k++) begin
                ga = a + k;
                ref_mem[key(p, ga)] = wd[8 * (ga % 4) +: 8];
                ref_bad[key(p, ga)] = PAR && pinj;
            end
        end
        last_q[p] = q_e;

        @(posedge clk); #1;
        check("pulse", {30'd0, ack[p], err[p]}, 32'd0);
    endtask

    task automatic rand_txn(input int p);
        logic [31:0] a;
        logic [2:0]  sz;
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0)      a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
        else if (r == 1) a = BASE - 32'd1 - 32'($urandom_range(0, 7));
        else             a = BASE + 32'($urandom_range(0, WIN * 4 - 1));
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        txn(p, a, $urandom, 1'($urandom_range(0, 1)), sz, PAR && ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation stalled, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            rst[p] = 1'b1; req[p] = 1'b0; adr[p] = '0; d[p] = '0;
            we[p] = 1'b0; size[p] = BYTE; inj[p] = 1'b0; last_q[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            check("rst_q", q[p], 32'd0);
            check("rst_flags", {28'd0, ack[p], err[p], mis[p], pf[p]}, 32'd0);
            rst[p] = 1'b0;
        end

        txn(0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1, 3'd2, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'h11, 32'h0000_5500, 1'b1, 3'd0, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'h12, 32'h1234_0000, 1'b1, 3'd1, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'h13, 32'h0,         1'b0, 3'd1, 1'b0);
        txn(0, BASE + 32'h11, 32'hFFFF_FFFF, 1'b1, 3'd2, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'(DEPTH * 4), 32'h0, 1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'(DEPTH * 4) - 32'd4, 32'hA5A5_0F0F, 1'b1, 3'd2, 1'b0);
        txn(0, BASE + 32'(DEPTH * 4) - 32'd4, 32'h0, 1'b0, 3'd2, 1'b0);
        txn(0, BASE - 32'd4,  32'h0,         1'b0, 3'd2, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b0, 3'd5, 1'b0);
        txn(0, BASE + 32'h10, 32'h0,         1'b1, 3'd3, 1'b0);

        txn(1, BASE + 32'h20, 32'hCAFE_F00D, 1'b1, 3'd2, 1'b0);
        txn(1, BASE + 32'h20, 32'h0,         1'b0, 3'd2, 1'b0);
        @(posedge clk); #1;
        req[1] = 1'b1; adr[1] = BASE + 32'h20; d[1] = 32'h1111_1111; we[1] = 1'b1; size[1] = WORD;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        req[1] = 1'b0;
        #1;
        check("midrst_q", q[1], 32'd0);
        check("midrst_flags", {28'd0, ack[1], err[1], mis[1], pf[1]}, 32'd0);
        @(posedge clk); #1;
        rst[1]    = 1'b0;
        last_q[1] = '0;
        txn(1, BASE + 32'h20, 32'h0, 1'b0, 3'd2, 1'b0);

`ifdef DMEM_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            txn(p, BASE + 32'h30, 32'h0F1E_2D3C, 1'b1, 3'd2, 1'b1);
            txn(p, BASE + 32'h30, 32'h0,         1'b0, 3'd2, 1'b0);
            txn(p, BASE + 32'h30, 32'h0F1E_2D3C, 1'b1, 3'd2, 1'b0);
            txn(p, BASE + 32'h30, 32'h0,         1'b0, 3'd2, 1'b0);
        end
`endif

        for (int p = 0; p < 2; p++) begin
            for (int unsigned w = 0; w < WIN; w++) txn(p, BASE + 32'(4 * w), $urandom, 1'b1, 3'd2, 1'b0);
            for (int n = 0; n < 60; n++) rand_txn(p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
